// File: rtl/lc3b_bus_arbiter.sv
// Round-robin arbiter for the LC-3b shared bus gates, with bounded tenure and
// break-before-make turnaround cycles between owners.
module lc3b_bus_arbiter #(
  parameter int unsigned N_REQ       = 5,
  parameter int unsigned OWNER_W     = 3,
  parameter int unsigned MAX_TENURE  = 8,
  parameter int unsigned TURN_CYCLES = 1
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic [N_REQ-1:0]   req,
  output logic [N_REQ-1:0]   gate_en,
  output logic [OWNER_W-1:0] owner,
  output logic               bus_busy,
  output logic               tenure_expired
);

  localparam int unsigned TEN_W = $clog2(MAX_TENURE + 1);
  localparam int unsigned TRN_W = $clog2(TURN_CYCLES + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_TURN  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [OWNER_W-1:0] last_owner_q, last_owner_d;
  logic [TEN_W-1:0]   ten_q, ten_d;
  logic [TRN_W-1:0]   turn_q, turn_d;
  logic [N_REQ-1:0]   gate_d;
  logic [OWNER_W-1:0] owner_d;
  logic               expired_d;

  logic [2*N_REQ-1:0] req_dbl;
  logic [N_REQ-1:0]   req_rot;
  logic               win_valid;
  logic [OWNER_W-1:0] win_idx;

  // Rotate requests so bit 0 is the driver right after the last owner.
  assign req_dbl = {req, req};
  assign req_rot = N_REQ'(req_dbl >> (int'(last_owner_q) + 1));

  always_comb begin
    win_valid = 1'b0;
    win_idx   = '0;
    for (int i = 0; i < int'(N_REQ); i++) begin
      if (!win_valid && req_rot[i]) begin
        win_valid = 1'b1;
        win_idx   = OWNER_W'((int'(last_owner_q) + 1 + i) % int'(N_REQ));
      end
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d      = state_q;
    last_owner_d = last_owner_q;
    ten_d        = ten_q;
    turn_d       = turn_q;
    gate_d       = gate_en;
    owner_d      = owner;
    expired_d    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        gate_d = '0;
        if (win_valid) begin
          state_d      = S_GRANT;
          gate_d       = N_REQ'(1) << win_idx;
          owner_d      = win_idx;
          last_owner_d = win_idx;
          ten_d        = TEN_W'(1);
        end
      end
      S_GRANT: begin
        if (!req[owner]) begin
          state_d = S_TURN;
          gate_d  = '0;
          ten_d   = '0;
          turn_d  = TRN_W'(1);
        end else if (ten_q == TEN_W'(MAX_TENURE)) begin
          state_d   = S_TURN;
          gate_d    = '0;
          ten_d     = '0;
          turn_d    = TRN_W'(1);
          expired_d = 1'b1;
        end else begin
          ten_d = ten_q + TEN_W'(1);
        end
      end
      S_TURN: begin
        gate_d = '0;
        if (turn_q == TRN_W'(TURN_CYCLES)) begin
          if (win_valid) begin
            state_d      = S_GRANT;
            gate_d       = N_REQ'(1) << win_idx;
            owner_d      = win_idx;
            last_owner_d = win_idx;
            ten_d        = TEN_W'(1);
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          turn_d = turn_q + TRN_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        gate_d  = '0;
      end
    endcase
  end

  // State and registered outputs, synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q        <= S_IDLE;
      last_owner_q   <= OWNER_W'(N_REQ - 1);
      ten_q          <= '0;
      turn_q         <= '0;
      gate_en        <= '0;
      owner          <= '0;
      bus_busy       <= 1'b0;
      tenure_expired <= 1'b0;
    end else begin
      state_q        <= state_d;
      last_owner_q   <= last_owner_d;
      ten_q          <= ten_d;
      turn_q         <= turn_d;
      gate_en        <= gate_d;
      owner          <= owner_d;
      bus_busy       <= |gate_d;
      tenure_expired <= expired_d;
    end
  end

endmodule

// File: doc/lc3b_bus_arbiter.md
Name: lc3b_bus_arbiter

Overview:
- Sequences the gate drivers of the LC-3b shared 16-bit bus (GatePC, GateMARMUX, GateALU, GateSHF, GateMDR) so that at most one tristate gate drives the bus at any time.
- Uses round-robin arbitration among the requesting drivers.
- Limits each grant to a bounded tenure.
- Inserts break-before-make turnaround cycles, with all gates off, between owners.
- Each gate_en bit wires directly to the enable input of one bus gate module.

Parameters:
- N_REQ, 5, number of bus drivers. Index 0=PC, 1=MARMUX, 2=ALU, 3=SHF, 4=MDR.
- OWNER_W, 3, width of the owner index. Must satisfy 2^OWNER_W >= N_REQ.
- MAX_TENURE, 8, maximum consecutive cycles one owner keeps its gate enabled. Must be >= 1.
- TURN_CYCLES, 1, number of all-gates-off cycles after every grant ends. Must be >= 1.

Ports:
- clock, input, 1: rising-edge clock.
- reset_n, input, 1: synchronous, active-low reset.
- req, input, N_REQ: per-driver bus request, level-sensitive, sampled on clock rising edge.
- gate_en, output, N_REQ: registered one-hot-or-zero gate enables, wired to the gate modules' enable inputs.
- owner, output, OWNER_W: index of the current or most recent owner.
- bus_busy, output, 1: high while any gate_en bit is set.
- tenure_expired, output, 1: one-cycle pulse when a grant is forcibly ended at MAX_TENURE.

Behaviour:
- Reset (edge with reset_n=0), from any state including mid-grant:
  - state=IDLE, gate_en=0, bus_busy=0, owner=0, tenure_expired=0, tenure counter=0, turn counter=0.
  - last_owner=N_REQ-1, so index 0 has top priority after reset.
- States: IDLE, GRANT, TURN. All outputs are registered.
- Round-robin pick: first set req bit scanning last_owner+1, last_owner+2, … modulo N_REQ. The scan wraps, so the scan position after index N_REQ-1 is index 0.
- IDLE:
  - gate_en=0.
  - On an edge where req != 0: go to GRANT, set gate_en[w]=1, owner=w, last_owner=w, tenure counter=1.
  - Latency: req high before edge k means gate_en is high after edge k.
- GRANT, on each edge:
  - If req[owner]=0: go to TURN, gate_en=0, tenure_expired=0.
  - Else if tenure counter == MAX_TENURE: go to TURN, gate_en=0, tenure_expired=1 for exactly one cycle.
  - Else: stay in GRANT, tenure counter +1.
  - req bits of non-owners are ignored during GRANT; no preemption by priority.
- TURN:
  - gate_en=0 for exactly TURN_CYCLES cycles.
  - At the edge ending the last TURN cycle, arbitrate as in IDLE:
    - If req != 0: go directly to GRANT with the winner.
    - Else: go to IDLE.
  - A requester that was cut off by MAX_TENURE and still requests goes to the back of the rotation. It is re-granted immediately after TURN only if no other req bit is set.
- Invariants:
  - gate_en is zero or exactly one-hot on every cycle.
  - gate_en never changes directly from one non-zero value to a different non-zero value. At least TURN_CYCLES zero cycles always separate two grants.
  - bus_busy == |gate_en.
  - owner holds its value when the bus is idle.
- req bits at index >= N_REQ do not exist. The counters saturate by the state rules above and never wrap.

Test Plan:
1. Reset: reset_n=0 for 2 cycles with req=5'b11111 -> gate_en=0, bus_busy=0, owner=0. Then release reset with req=5'b00100 -> gate_en=5'b00100 and owner=2 after the first edge.
2. Round-robin under full load: req=5'b11111 held, defaults.
   - Owners go 0,1,2,3,4,0.
   - Each owner is enabled 8 cycles, then 1 zero cycle.
   - tenure_expired pulses once per grant, in the zero cycle.
3. Early release: req[0] high for 3 cycles then low, req[3] held high.
   - gate_en=5'b00001 for 3 cycles, then 5'b00000 for 1 cycle, then 5'b01000.
   - tenure_expired stays 0 throughout.
4. Lone requester over limit: req=5'b00010 held 30 cycles.
   - Repeating pattern: 8 cycles gate_en=5'b00010, 1 cycle zero.
   - tenure_expired pulses 3 times.
   - owner stays 1.
5. Reset mid-grant: assert reset_n=0 on the 4th cycle of owner 4 -> gate_en=0 on the next edge. After release with req=5'b10001, owner 0 wins.
6. Random req, 10k cycles, TURN_CYCLES=2: assert gate_en is one-hot-or-zero and never switches between non-zero values without 2 zero cycles. No requester starves for more than (N_REQ-1)*(MAX_TENURE+TURN_CYCLES)+TURN_CYCLES cycles.
